mdll_jm_meas: RTL
=================

Name: mdll_jm_meas

Overview:
Parametrised multi-channel jitter-measurement counter for the MDLL tracking loop. Over a programmable window of reference cycles it counts the 1s on each channel's sampled phase-detector bit (BB/TDC 1b outputs, already retimed to clk_ref). It replaces the single-channel, fixed-width jm_out path. It adds per-channel saturation flags, a done/valid handshake, abort, and a continuous re-arm mode. It sits in mdll_synth beside the loop filter and drives the jm_out register bank.

Parameters:
NCH, 2, number of measured channels (>=1)
CNT_W, 20, per-channel result width
NCYC_W, 16, width of window-length control

Ports:
clk_ref  in  1  measurement clock (divided reference); all logic on rising edge
rstb  in  1  asynchronous active-low reset
en_jm  in  1  block enable (level)
start  in  1  start request; sampled only in IDLE
cont  in  1  continuous mode (1: auto re-arm after each window)
ncycle  in  NCYC_W  window length minus 1; latched when a window starts
sample  in  NCH  per-channel PD bit, synchronous to clk_ref
jm_out  out  NCH*CNT_W  results; channel i at [i*CNT_W +: CNT_W]
jm_ovf  out  NCH  per-channel saturation flag for last result
jm_valid  out  1  at least one result completed since reset
done  out  1  one-cycle pulse per completed window
busy  out  1  high in RUN and DONE

Behaviour:
- Reset (rstb=0, async): state=IDLE. jm_out, jm_ovf, jm_valid, done, busy, internal accumulators and window counter all 0.
- States: IDLE, RUN, DONE. State, accumulators (CNT_W each) and window counter (NCYC_W) are registered.
- IDLE -> RUN: at an edge with en_jm=1 and start=1. On that edge: wcnt<=ncycle, acc[i]<=0.
- RUN, each edge:
  - en_jm=0: abort -> IDLE. jm_out, jm_ovf, jm_valid unchanged. No done.
  - wcnt!=0: acc[i]<=sat(acc[i]+sample[i]), ovf_int[i] sticky-set if the add saturates; wcnt<=wcnt-1.
  - wcnt==0: jm_out[i]<=sat(acc[i]+sample[i]); jm_ovf[i]<=ovf_int[i] | final-add saturation; jm_valid<=1; done<=1; -> DONE.
- Window length: exactly N=ncycle+1 samples per channel. ncycle=0 gives 1 sample.
- Latency: the start edge is k. Samples at edges k+1..k+N are counted. jm_out updates at edge k+N. done is high during the cycle after edge k+N.
- DONE (one cycle): done<=0 at the next edge. acc, ovf_int cleared; wcnt<=ncycle (re-latched).
  - cont=1 & en_jm=1 -> RUN. Results update every N+1 cycles; the DONE-cycle sample is not counted.
  - Otherwise -> IDLE.
- Saturation: accumulators clamp at 2^CNT_W-1 and never wrap. ovf is sticky within a window and reported per window.
- start is ignored outside IDLE and when en_jm=0. ncycle changes mid-window have no effect.
- busy = (state!=IDLE), registered with state.
- jm_out holds its last value until the next completed window. Partial accumulations are never visible.
- Channels are independent; all share one window counter and one FSM.

Test Plan:
- NCH=2, ncycle=9, sample=2'b01 constant, single start -> done once, 11 cycles after the start edge (high in the cycle after edge k+10); jm_out ch0=10, ch1=0; jm_ovf=0; jm_valid=1; returns to IDLE.
- ncycle=0, sample=2'b11 -> jm_out ch0=ch1=1; done pulse in the second cycle after the start edge.
- CNT_W=4 override, ncycle=19, sample all 1s -> jm_out=15 each, jm_ovf=2'b11. A following window with ncycle=3 and sample=1 gives 4, ovf=0.
- cont=1, ncycle=4, ch0 toggling 1,0,1,... -> done every 6 cycles while en_jm=1. Each result is 3 or 2 depending on phase. Drop en_jm mid-window -> IDLE, no done, jm_out keeps the last result.
- rstb pulsed low mid-RUN -> all outputs 0 immediately (async). A start issued after rstb rises completes normally.
- start asserted during RUN and with en_jm=0 in IDLE -> ignored; busy stays as per state.

Source files
------------

// File: rtl/mdll_jm_meas.sv
// rtl/mdll_jm_meas.sv - multi-channel windowed ones-counter for MDLL jitter measurement
module mdll_jm_meas #(
    parameter int NCH    = 2,
    parameter int CNT_W  = 20,
    parameter int NCYC_W = 16
) (
    input  logic                 clk_ref,
    input  logic                 rstb,
    input  logic                 en_jm,
    input  logic                 start,
    input  logic                 cont,
    input  logic [NCYC_W-1:0]    ncycle,
    input  logic [NCH-1:0]       sample,
    output logic [NCH*CNT_W-1:0] jm_out,
    output logic [NCH-1:0]       jm_ovf,
    output logic                 jm_valid,
    output logic                 done,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [NCYC_W-1:0] wcnt;
    logic [CNT_W-1:0]  acc     [NCH];
    logic [CNT_W-1:0]  acc_sum [NCH];
    logic [NCH-1:0]    ovf_int;
    logic [NCH-1:0]    sat_hit;

    // A full accumulator absorbs further ones instead of wrapping.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sat_hit[i] = sample[i] && (acc[i] == {CNT_W{1'b1}});
            acc_sum[i] = sat_hit[i] ? acc[i] : acc[i] + CNT_W'(sample[i]);
        end
    end

    always_ff @(posedge clk_ref or negedge rstb) begin
        if (!rstb) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            ovf_int  <= '0;
            jm_out   <= '0;
            jm_ovf   <= '0;
            jm_valid <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en_jm && start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        wcnt    <= ncycle;
                        ovf_int <= '0;
                        for (int i = 0; i < NCH; i++) acc[i] <= '0;
                    end
                end
                S_RUN: begin
                    if (!en_jm) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (wcnt != '0) begin
                        for (int i = 0; i < NCH; i++) acc[i] <= acc_sum[i];
                        ovf_int <= ovf_int | sat_hit;
                        wcnt    <= wcnt - NCYC_W'(1);
                    end else begin
                        // Final sample goes straight into the result; acc itself is never exposed.
                        for (int i = 0; i < NCH; i++) jm_out[i*CNT_W +: CNT_W] <= acc_sum[i];
                        jm_ovf   <= ovf_int | sat_hit;
                        jm_valid <= 1'b1;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ovf_int <= '0;
                    wcnt    <= ncycle;
                    for (int i = 0; i < NCH; i++) acc[i] <= '0;
                    if (cont && en_jm) begin
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
